// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and widths for the MEM pipeline stage.
//   state_t    : access FSM states (IDLE, WAIT)
//   WORD_W     : datapath width
//   REGADDR_W  : register-file address width
//   CNT_W      : width of the wait counter (covers MAX_WAIT up to 255)
//   is_aligned : true when a byte address is word aligned
package mem_stage_pkg;

    localparam int WORD_W    = 32;
    localparam int REGADDR_W = 5;
    localparam int CNT_W     = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall               : stage is frozen this cycle -> insert a bubble, hold data
//   valid, reg_write    : slot qualifiers to capture when not stalled
//   write_address       : destination register to capture
//   result              : selected writeback value to capture
//   wb_valid, wb_reg_write, wb_write_address, wb_result : registered outputs
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 valid,
    input  logic                 reg_write,
    input  logic [REGADDR_W-1:0] write_address,
    input  logic [WORD_W-1:0]    result,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REGADDR_W-1:0] wb_write_address,
    output logic [WORD_W-1:0]    wb_result
);

    // Capture the slot when the stage advances; while stalled emit a bubble and keep the data fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid         <= 1'b0;
            wb_reg_write     <= 1'b0;
            wb_write_address <= {REGADDR_W{1'b0}};
            wb_result        <= {WORD_W{1'b0}};
        end else if (stall) begin
            wb_valid         <= 1'b0;
        end else begin
            wb_valid         <= valid;
            wb_reg_write     <= reg_write;
            wb_write_address <= write_address;
            wb_result        <= result;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of a 5-stage pipeline with a req/ack data-memory port.
//   Parameter MAX_WAIT (1..255): request cycles, counting the first, before an access is aborted.
//   Inputs : clk, rst_n, EX/MEM controls (in_valid, branch, zero, mem_read, mem_write,
//            mem_to_reg, reg_write), write_address, alu_result, read_out2,
//            dmem_rdata, dmem_ack.
//   Outputs: dmem_req/we/addr/wdata, stall, pc_src, mem_err, MEM/WB slot (wb_*).
//   Build option: MEM_ALIGN_CHECK_EN rejects non-word-aligned accesses without touching memory.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 branch,
    input  logic                 zero,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 mem_to_reg,
    input  logic                 reg_write,
    input  logic [REGADDR_W-1:0] write_address,
    input  logic [WORD_W-1:0]    alu_result,
    input  logic [WORD_W-1:0]    read_out2,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [WORD_W-1:0]    dmem_addr,
    output logic [WORD_W-1:0]    dmem_wdata,
    input  logic [WORD_W-1:0]    dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 stall,
    output logic                 pc_src,
    output logic                 mem_err,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REGADDR_W-1:0] wb_write_address,
    output logic [WORD_W-1:0]    wb_result
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    state_t             state_r, state_nx_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
    logic               access_raw_s, access_s, misalign_s;
    logic               req_s, stall_s, done_s, abort_s, kill_s;
    logic [WORD_W-1:0]  result_s;

    assign access_raw_s = in_valid & (mem_read | mem_write);

    // Misaligned accesses are dropped before they reach the FSM when the check is built in.
    always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s = access_raw_s & ~is_aligned(alu_result);
`else
        misalign_s = 1'b0;
`endif
    end

    assign access_s = access_raw_s & ~misalign_s;

    // FSM state and wait counter; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next state and request/stall decode. At the final allowed count the request is
    // withdrawn and the slot is released as a bubble.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        req_s      = 1'b0;
        stall_s    = 1'b0;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (access_s) begin
                    req_s = 1'b1;
                    if (dmem_ack) begin
                        done_s = 1'b1;
                    end else begin
                        stall_s    = 1'b1;
                        state_nx_s = ST_WAIT;
                        cnt_nx_s   = CNT_W'(1);
                    end
                end else begin
                    cnt_nx_s = {CNT_W{1'b0}};
                end
            end
            ST_WAIT: begin
                if (cnt_r >= MAX_WAIT_C) begin
                    abort_s    = 1'b1;
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else if (dmem_ack) begin
                    req_s      = 1'b1;
                    done_s     = 1'b1;
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else begin
                    req_s    = 1'b1;
                    stall_s  = 1'b1;
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Reset must silence the memory port and release the pipeline without waiting for a clock.
    assign dmem_req   = rst_n & req_s;
    assign stall      = rst_n & stall_s;
    assign dmem_we    = mem_write;
    assign dmem_addr  = alu_result;
    assign dmem_wdata = read_out2;
    assign pc_src     = in_valid & branch & zero;

    assign kill_s   = abort_s | misalign_s;
    assign result_s = (mem_to_reg & done_s) ? dmem_rdata : alu_result;

    // Error pulse follows the cycle in which an access was aborted or rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= kill_s;
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall_s),
        .valid            (in_valid & ~kill_s),
        .reg_write        (reg_write & ~kill_s),
        .write_address    (write_address),
        .result           (result_s),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .wb_write_address (wb_write_address),
        .wb_result        (wb_result)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (MAX_WAIT=4).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later, registered outputs 1 unit after the next rising edge.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid, branch, zero, mem_read, mem_write, mem_to_reg, reg_write;
    logic [4:0]  write_address;
    logic [31:0] alu_result, read_out2;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall, pc_src, mem_err;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_write_address;
    logic [31:0] wb_result;

    int total = 0;
    int bad   = 0;

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .branch           (branch),
        .zero             (zero),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_to_reg       (mem_to_reg),
        .reg_write        (reg_write),
        .write_address    (write_address),
        .alu_result       (alu_result),
        .read_out2        (read_out2),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ack         (dmem_ack),
        .stall            (stall),
        .pc_src           (pc_src),
        .mem_err          (mem_err),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .wb_write_address (wb_write_address),
        .wb_result        (wb_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; branch = 1'b0; zero = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0;
        write_address = 5'd0; alu_result = 32'd0; read_out2 = 32'd0;
        dmem_rdata = 32'd0; dmem_ack = 1'b0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
        in_valid = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
        mem_write = 1'b0; alu_result = addr; write_address = rd;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #12;
        // reset state
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_result", wb_result, 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU pass-through
        in_valid = 1'b1; reg_write = 1'b1; alu_result = 32'h0000_1234; write_address = 5'd7;
        #1;
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_req", 32'(dmem_req), 32'd0);
        tick();
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_wb_result", wb_result, 32'h0000_1234);
        chk("alu_wb_addr", 32'(wb_write_address), 32'd7);
        clear_inputs();

        // load 0x40, ack on third request cycle
        set_load(32'h0000_0040, 5'd3);
        #1;
        chk("ld_c0_req", 32'(dmem_req), 32'd1);
        chk("ld_c0_stall", 32'(stall), 32'd1);
        chk("ld_we", 32'(dmem_we), 32'd0);
        chk("ld_addr", dmem_addr, 32'h0000_0040);
        tick();
        chk("ld_bubble1", 32'(wb_valid), 32'd0);
        chk("ld_c1_stall", 32'(stall), 32'd1);
        chk("ld_c1_req", 32'(dmem_req), 32'd1);
        tick();
        chk("ld_bubble2", 32'(wb_valid), 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_c2_stall", 32'(stall), 32'd0);
        chk("ld_c2_req", 32'(dmem_req), 32'd1);
        tick();
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_wb_result", wb_result, 32'hDEAD_BEEF);
        chk("ld_wb_regwr", 32'(wb_reg_write), 32'd1);
        chk("ld_wb_addr", 32'(wb_write_address), 32'd3);
        clear_inputs();

        // store 0x55 to 0x80, same-cycle ack
        in_valid = 1'b1; mem_write = 1'b1; alu_result = 32'h0000_0080;
        read_out2 = 32'h0000_0055; dmem_ack = 1'b1;
        #1;
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_wdata", dmem_wdata, 32'h0000_0055);
        chk("st_req", 32'(dmem_req), 32'd1);
        chk("st_stall", 32'(stall), 32'd0);
        tick();
        chk("st_wb_valid", 32'(wb_valid), 32'd1);
        chk("st_wb_regwr", 32'(wb_reg_write), 32'd0);
        clear_inputs();

        // timeout: MAX_WAIT=4, no ack
        set_load(32'h0000_0100, 5'd9);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_req_c%0d", i), 32'(dmem_req), 32'd1);
            chk($sformatf("to_stall_c%0d", i), 32'(stall), 32'd1);
            chk($sformatf("to_err_c%0d", i), 32'(mem_err), 32'd0);
            tick();
        end
        #1;
        chk("to_abort_req", 32'(dmem_req), 32'd0);
        chk("to_abort_stall", 32'(stall), 32'd0);
        tick();
        chk("to_err_pulse", 32'(mem_err), 32'd1);
        chk("to_wb_valid", 32'(wb_valid), 32'd0);
        chk("to_wb_regwr", 32'(wb_reg_write), 32'd0);
        clear_inputs();
        dmem_ack = 1'b1;
        #1;
        chk("stray_req", 32'(dmem_req), 32'd0);
        chk("stray_stall", 32'(stall), 32'd0);
        tick();
        chk("err_one_cycle", 32'(mem_err), 32'd0);
        chk("stray_wb_valid", 32'(wb_valid), 32'd0);
        clear_inputs();

        // ALU op to leave a nonzero MEM/WB before the reset test
        in_valid = 1'b1; reg_write = 1'b1; alu_result = 32'h0000_0ABC; write_address = 5'd5;
        tick();
        chk("pre_rst_wb_result", wb_result, 32'h0000_0ABC);
        clear_inputs();

        // reset during the second WAIT cycle
        set_load(32'h0000_0200, 5'd4);
        tick();
        tick();
        #1;
        chk("rw_req_before", 32'(dmem_req), 32'd1);
        chk("rw_stall_before", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_req", 32'(dmem_req), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        chk("rw_wb_valid", 32'(wb_valid), 32'd0);
        chk("rw_wb_result", wb_result, 32'd0);
        chk("rw_wb_addr", 32'(wb_write_address), 32'd0);
        chk("rw_mem_err", 32'(mem_err), 32'd0);
        clear_inputs();
        #2;
        rst_n = 1'b1;
        tick();
        chk("rw_no_retry_req", 32'(dmem_req), 32'd0);
        chk("rw_post_stall", 32'(stall), 32'd0);
        chk("rw_post_err", 32'(mem_err), 32'd0);

        // branch decision
        in_valid = 1'b1; branch = 1'b1; zero = 1'b1;
        #1;
        chk("br_taken", 32'(pc_src), 32'd1);
        chk("br_stall", 32'(stall), 32'd0);
        zero = 1'b0;
        #1;
        chk("br_not_taken", 32'(pc_src), 32'd0);
        in_valid = 1'b0; zero = 1'b1;
        #1;
        chk("br_invalid", 32'(pc_src), 32'd0);
        clear_inputs();
        tick();

        // misaligned load at 0x42
        set_load(32'h0000_0042, 5'd6);
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        chk("al_req", 32'(dmem_req), 32'd0);
        chk("al_stall", 32'(stall), 32'd0);
        tick();
        chk("al_err", 32'(mem_err), 32'd1);
        chk("al_wb_valid", 32'(wb_valid), 32'd0);
`else
        dmem_ack = 1'b1; dmem_rdata = 32'h0000_0011;
        #1;
        chk("al_req", 32'(dmem_req), 32'd1);
        chk("al_addr", dmem_addr, 32'h0000_0042);
        tick();
        chk("al_err", 32'(mem_err), 32'd0);
        chk("al_wb_result", wb_result, 32'h0000_0011);
`endif
        clear_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
